// File: rtl/delete0_pkg.sv
// Shared definitions for the zero-deletion receiver: widths, FSM encoding and the
// start edge-detect rule used by both ends of the stuffing link.
package delete0_pkg;

    localparam int unsigned DB_W     = 10;
    localparam int unsigned ONES_MAX = 5;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRecv = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Frame start is the rising edge of the level flag against its registered copy.
    function automatic logic start_edge(input logic flag, input logic flag_d1);
        return flag & ~flag_d1;
    endfunction

endpackage

// File: rtl/delete0_destuff_core.sv
// Consecutive-ones tracker: decides whether each valid bit is data, a stuffed zero,
// or a stuffing violation.
module delete0_destuff_core #(
    parameter int unsigned ONES_MAX = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inr,
    input  logic en,
    input  logic bit_valid,
    input  logic bit_in,
    output logic keep_bit,
    output logic drop_bit,
    output logic err
);

    logic [2:0] ones_q, ones_d;
    logic       at_max;

    always_comb begin
        at_max   = (ones_q == 3'(ONES_MAX));
        keep_bit = en & bit_valid & ~at_max;
        drop_bit = en & bit_valid & at_max & ~bit_in;
        err      = en & bit_valid & at_max & bit_in;
        ones_d   = ones_q;
        if (!en || drop_bit || err) begin
            ones_d = '0;
        end else if (keep_bit) begin
            ones_d = bit_in ? ones_q + 3'd1 : 3'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_q <= '0;
        end else if (inr) begin
            ones_q <= '0;
        end else begin
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/delete0.sv
// Zero-deletion receiver: strips stuffed zeros, reassembles LSB-first bytes and
// frames them against a byte count latched at start.
module delete0 #(
    parameter int unsigned DB_W     = delete0_pkg::DB_W,
    parameter int unsigned ONES_MAX = delete0_pkg::ONES_MAX
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inr,
    input  logic            trastart_flag,
    input  logic [DB_W-1:0] db,
    input  logic            bit_valid,
    input  logic            bit_in,
    output logic [7:0]      byte_out,
    output logic            byte_valid,
    output logic [DB_W-1:0] byte_cnt,
    output logic            busy,
    output logic            done,
    output logic            stuff_err
);

    import delete0_pkg::*;

    logic [1:0]      state_q, state_d;
    logic            flag_d1_q, start_q, start_d;
    logic [DB_W-1:0] db_r_q, db_r_d;
    logic [DB_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]      sh_q, sh_d;
    logic [2:0]      bit_cnt_q, bit_cnt_d;
    logic [7:0]      byte_out_q, byte_out_d;
    logic            byte_valid_q, byte_valid_d;
    logic            stuff_err_q, stuff_err_d;
    logic            frame_end, en;
    logic            keep_bit, drop_bit, err;

    // The strobe cycle of the final byte closes the frame; bits there are not taken.
    assign frame_end = byte_valid_q && (byte_cnt_q == db_r_q);
    assign en        = (state_q == StRecv) && !frame_end;

    delete0_destuff_core #(
        .ONES_MAX (ONES_MAX)
    ) u_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .inr       (inr),
        .en        (en),
        .bit_valid (bit_valid),
        .bit_in    (bit_in),
        .keep_bit  (keep_bit),
        .drop_bit  (drop_bit),
        .err       (err)
    );

    always_comb begin
        state_d      = state_q;
        db_r_d       = db_r_q;
        byte_cnt_d   = byte_cnt_q;
        sh_d         = sh_q;
        bit_cnt_d    = bit_cnt_q;
        byte_out_d   = '0;
        byte_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        start_d      = start_edge(trastart_flag, flag_d1_q);
        unique case (state_q)
            StIdle: begin
                if (start_q) begin
                    db_r_d     = db;
                    byte_cnt_d = '0;
                    sh_d       = '0;
                    bit_cnt_d  = '0;
                    state_d    = (db == '0) ? StDone : StRecv;
                end
            end
            StRecv: begin
                if (err) begin
                    stuff_err_d = 1'b1;
                    sh_d        = '0;
                    bit_cnt_d   = '0;
                    state_d     = StIdle;
                end else if (frame_end) begin
                    state_d = StDone;
                end else if (drop_bit) begin
                    bit_cnt_d = bit_cnt_q;
                end else if (keep_bit) begin
                    sh_d      = {bit_in, sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        byte_valid_d = 1'b1;
                        byte_out_d   = sh_d;
                        if (byte_cnt_q < db_r_q) begin
                            byte_cnt_d = byte_cnt_q + DB_W'(1);
                        end
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            flag_d1_q    <= 1'b0;
            start_q      <= 1'b0;
            db_r_q       <= '0;
            byte_cnt_q   <= '0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else if (inr) begin
            state_q      <= StIdle;
            flag_d1_q    <= 1'b0;
            start_q      <= 1'b0;
            db_r_q       <= '0;
            byte_cnt_q   <= '0;
            sh_q         <= '0;
            bit_cnt_q    <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            flag_d1_q    <= trastart_flag;
            start_q      <= start_d;
            db_r_q       <= db_r_d;
            byte_cnt_q   <= byte_cnt_d;
            sh_q         <= sh_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign byte_out   = byte_out_q;
    assign byte_valid = byte_valid_q;
    assign byte_cnt   = byte_cnt_q;
    assign busy       = (state_q == StRecv);
    assign done       = (state_q == StDone);
    assign stuff_err  = stuff_err_q;

endmodule

// File: doc/delete0.md
Name: delete0

Overview:
- Receive-side counterpart of the zero-insertion transmitter: accepts the serial bit stream produced by zero-bit insertion and removes each stuffed 0 that follows five consecutive 1s.
- Reassembles the data bits LSB-first into bytes and presents each byte with a one-cycle valid strobe, plus the running byte count.
- A frame is armed by a start pulse and ends after db bytes have been output; a run of six 1s is flagged as a stuffing error.

Parameters:
DB_W, 10, width of byte-count input db and output byte_cnt
ONES_MAX, 5, consecutive-1 run length after which the next bit is a stuffed 0

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
inr  input  1  synchronous clear; highest priority after rst_n
trastart_flag  input  1  frame start level; rising edge (registered edge detect, as transmitter) arms frame
db  input  DB_W  expected payload bytes per frame; sampled at start
bit_valid  input  1  bit_in valid this cycle (gaps allowed)
bit_in  input  1  serial stuffed data, LSB of each byte first
byte_out  output  8  reassembled byte; 0 when byte_valid=0
byte_valid  output  1  one-cycle strobe per completed byte
byte_cnt  output  DB_W  bytes output so far in current frame
busy  output  1  high in RECV state
done  output  1  one-cycle pulse at frame completion
stuff_err  output  1  one-cycle pulse on six consecutive 1s

Behaviour:
- Reset (rst_n=0) and inr=1: all outputs 0; state IDLE; internal counters 0; edge-detect register 0.
- Start pulse: start = trastart_flag & ~trastart_d1, both registered. It is accepted only in IDLE. On acceptance, db is latched into db_r.
- FSM states: IDLE, RECV, DONE.
- IDLE -> RECV on start with db!=0.
- IDLE -> DONE on start with db==0. No bytes are output in this case.
- RECV -> DONE when the byte making byte_cnt==db_r is emitted.
- RECV -> IDLE on a stuffing error.
- DONE -> IDLE unconditionally after 1 cycle. done=1 during the DONE cycle.
- Bit handling, in RECV only, on cycles with bit_valid=1:
  - ones_cnt (3b) counts consecutive accepted 1s.
  - If ones_cnt==ONES_MAX and bit_in==0: the bit is deleted (not shifted in) and ones_cnt <= 0.
  - If ones_cnt==ONES_MAX and bit_in==1: stuff_err pulses next cycle, the partial byte is discarded, and the FSM goes to IDLE.
  - Otherwise: the bit is shifted into the shift register as {bit_in, sh[7:1]} and bit_cnt increments. A 1 increments ones_cnt; a 0 clears it.
- bit_valid=0 cycles hold all RECV state. Bits arriving outside RECV are ignored.
- Byte completion: when the 8th data bit is shifted in (bit_cnt 7->0 wrap), the next cycle has:
  - byte_valid=1
  - byte_out = assembled byte
  - byte_cnt incremented
  - Latency: 1 cycle from the accepting clock edge.
- ones_cnt is not cleared at byte boundaries; stuffing runs across bytes.
- byte_cnt saturates at db_r. It holds its value through DONE and IDLE until the next start, inr, or reset.
- Start while in RECV or DONE is ignored.
- inr mid-frame: immediate return to IDLE with no done pulse.
- Reset mid-frame: same as inr, but asynchronous.

Decomposition:
- Shared package holds:
  - DB_W
  - ONES_MAX
  - FSM state encoding (IDLE=2'd0, RECV=2'd1, DONE=2'd2)
  - the start edge-detect convention, shared with the insertion transmitter
- One natural sub-module, destuff_core: ones counter plus delete/error decision. It takes bit_valid and bit_in and produces keep_bit, drop_bit and err. The top holds the FSM, shift register and byte counting.

Test Plan:
- db=1, start, bits 1,0,1,0,0,1,0,1 (no stuffing) -> one byte_valid with byte_out=0xA5, byte_cnt=1, done 1 cycle after byte_valid.
- db=1, bits 1,1,1,1,1,0(stuffed),0,0,0 -> byte_out=0x1F; the stuffed 0 is not counted; no stuff_err.
- db=2, bytes 0xFF,0x00 sent as 1,1,1,1,1,0s,1,1,1,0,0,0,0,0,0,0,0 -> 0xFF then 0x00, byte_cnt=2, done. Confirms ones_cnt carries across the byte boundary.
- db=1, bits 1,1,1,1,1,1 -> stuff_err pulse, no byte_valid, busy=0, next start accepted normally.
- db=3, inr=1 after 12 valid bits -> busy=0 and byte_cnt=0 next cycle, no done. A following frame with db=1, 0x3C decodes correctly.
- db=0 start -> done one cycle after start acceptance, byte_valid never asserted. A bit_valid gap of 4 cycles mid-byte -> same byte result as without the gap.
